// File: rtl/regfile_pkg.sv
// Shared register-file constants, address/data types and the write-queue entry record.
package regfile_pkg;

   localparam int unsigned REG_AW    = 6;
   localparam int unsigned REG_DW    = 32;
   localparam int unsigned REG_COUNT = 64;

   typedef logic [REG_AW-1:0] reg_addr_t;
   typedef logic [REG_DW-1:0] reg_data_t;

   typedef struct packed {
      logic      valid;
      reg_addr_t rd;
      reg_data_t data;
   } wq_entry_t;

endpackage

// File: rtl/wq_fwd_match.sv
// Youngest-first search of the write-queue entries for one read address.
// With REG_ZERO_DISCARD_EN defined, register 0 never produces a hit.
module wq_fwd_match
   import regfile_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  wq_entry_t [DEPTH-1:0]         entries_i,
   input  logic      [$clog2(DEPTH)-1:0] wr_idx_i,
   input  reg_addr_t                     rs_i,
   output logic                          hit_o,
   output reg_data_t                     data_o
);

   localparam int unsigned IW = $clog2(DEPTH);

   logic rs_allowed;

   always_comb begin
`ifdef REG_ZERO_DISCARD_EN
      rs_allowed = (rs_i != '0);
`else
      rs_allowed = 1'b1;
`endif
   end

   // Walk backwards from the slot just below wr_idx, so the first match is the youngest.
   always_comb begin : p_search
      logic [IW-1:0] idx;
      hit_o  = 1'b0;
      data_o = '0;
      idx    = '0;
      for (int unsigned k = 1; k <= DEPTH; k++) begin
         idx = wr_idx_i - IW'(k);
         if (!hit_o && rs_allowed && entries_i[idx].valid && (entries_i[idx].rd == rs_i)) begin
            hit_o  = 1'b1;
            data_o = entries_i[idx].data;
         end
      end
   end

endmodule

// File: rtl/regfile_write_queue.sv
// Buffered write port for the 64x32 register file with read-before-write forwarding.
// Optional macro REG_ZERO_DISCARD_EN: accepted writes to register 0 are dropped.
module regfile_write_queue
   import regfile_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = REG_AW,
   parameter int unsigned DW    = REG_DW
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [AW-1:0]          in_rd,
   input  logic [DW-1:0]          in_data,
   input  logic                   hold,
   output logic                   wrt,
   output logic [AW-1:0]          rd,
   output logic [DW-1:0]          dataIn,
   input  logic [AW-1:0]          rs1,
   input  logic [AW-1:0]          rs2,
   output logic                   fwd1_hit,
   output logic [DW-1:0]          fwd1_data,
   output logic                   fwd2_hit,
   output logic [DW-1:0]          fwd2_data,
   output logic [$clog2(DEPTH):0] pend_count
);

   localparam int unsigned IW = $clog2(DEPTH);
   localparam int unsigned PW = IW + 1;

   wq_entry_t [DEPTH-1:0] entries_q, entries_d;
   logic      [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic      [PW-1:0]    rd_ptr_q, rd_ptr_d;

   logic          empty;
   logic          full;
   logic          accept;
   logic          store;
   logic          deq;
   logic [IW-1:0] wr_idx;
   logic [IW-1:0] rd_idx;
   wq_entry_t     head;

   assign wr_idx = wr_ptr_q[IW-1:0];
   assign rd_idx = rd_ptr_q[IW-1:0];
   assign head   = entries_q[rd_idx];

   // Pointer MSB separates a full ring from an empty one.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_idx == rd_idx) && (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]);

   assign in_ready = !full;
   assign accept   = in_valid && in_ready;

   always_comb begin
`ifdef REG_ZERO_DISCARD_EN
      store = accept && (in_rd != '0);
`else
      store = accept;
`endif
   end

   assign deq        = !empty && !hold && !rst;
   assign wrt        = deq;
   assign rd         = empty ? '0 : AW'(head.rd);
   assign dataIn     = empty ? '0 : DW'(head.data);
   assign pend_count = wr_ptr_q - rd_ptr_q;

   // Store and dequeue never hit the same slot: that needs a full ring (no store) or an empty one
   // (no dequeue).
   always_comb begin
      entries_d = entries_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      if (deq) begin
         entries_d[rd_idx].valid = 1'b0;
         rd_ptr_d                = rd_ptr_q + 1'b1;
      end
      if (store) begin
         entries_d[wr_idx].valid = 1'b1;
         entries_d[wr_idx].rd    = reg_addr_t'(in_rd);
         entries_d[wr_idx].data  = reg_data_t'(in_data);
         wr_ptr_d                = wr_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         entries_q <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
      end else begin
         entries_q <= entries_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
      end
   end

   reg_data_t match1_data;
   reg_data_t match2_data;

   wq_fwd_match #(
      .DEPTH (DEPTH)
   ) u_fwd1 (
      .entries_i (entries_q),
      .wr_idx_i  (wr_idx),
      .rs_i      (reg_addr_t'(rs1)),
      .hit_o     (fwd1_hit),
      .data_o    (match1_data)
   );

   wq_fwd_match #(
      .DEPTH (DEPTH)
   ) u_fwd2 (
      .entries_i (entries_q),
      .wr_idx_i  (wr_idx),
      .rs_i      (reg_addr_t'(rs2)),
      .hit_o     (fwd2_hit),
      .data_o    (match2_data)
   );

   assign fwd1_data = DW'(match1_data);
   assign fwd2_data = DW'(match2_data);

endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed vector bench for regfile_write_queue; also covers REG_ZERO_DISCARD_EN when defined.
module tb_regfile_write_queue;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  in_rd;
   logic [31:0] in_data;
   logic        hold;
   logic        wrt;
   logic [5:0]  rd;
   logic [31:0] dataIn;
   logic [5:0]  rs1;
   logic [5:0]  rs2;
   logic        fwd1_hit;
   logic [31:0] fwd1_data;
   logic        fwd2_hit;
   logic [31:0] fwd2_data;
   logic [2:0]  pend_count;

   int n_pass  = 0;
   int n_total = 0;

   logic [5:0]  log_rd[$];
   logic [31:0] log_data[$];
   logic [5:0]  exp_rd[$];
   logic [31:0] exp_data[$];

   regfile_write_queue dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_rd      (in_rd),
      .in_data    (in_data),
      .hold       (hold),
      .wrt        (wrt),
      .rd         (rd),
      .dataIn     (dataIn),
      .rs1        (rs1),
      .rs2        (rs2),
      .fwd1_hit   (fwd1_hit),
      .fwd1_data  (fwd1_data),
      .fwd2_hit   (fwd2_hit),
      .fwd2_data  (fwd2_data),
      .pend_count (pend_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register-file side: record every write the register file would capture.
   always @(posedge clk) begin
      if (wrt === 1'b1) begin
         log_rd.push_back(rd);
         log_data.push_back(dataIn);
      end
   end

   typedef struct {
      logic        rst;
      logic        vld;
      logic [5:0]  ird;
      logic [31:0] idata;
      logic        hold;
      logic [5:0]  rs1;
      logic [5:0]  rs2;
      logic        e_wrt;
      logic [5:0]  e_rd;
      logic [31:0] e_din;
      logic        e_h1;
      logic [31:0] e_d1;
      logic        e_h2;
      logic [31:0] e_d2;
      logic [2:0]  e_cnt;
      logic        e_rdy;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic r, logic v, int ird, int idata, logic h, int a1, int a2,
                               logic ew, int erd, int edin, logic eh1, int ed1, logic eh2,
                               int ed2, int ecnt, logic erdy);
      vec_t t;
      t.rst   = r;
      t.vld   = v;
      t.ird   = 6'(ird);
      t.idata = 32'(idata);
      t.hold  = h;
      t.rs1   = 6'(a1);
      t.rs2   = 6'(a2);
      t.e_wrt = ew;
      t.e_rd  = 6'(erd);
      t.e_din = 32'(edin);
      t.e_h1  = eh1;
      t.e_d1  = 32'(ed1);
      t.e_h2  = eh2;
      t.e_d2  = 32'(ed2);
      t.e_cnt = 3'(ecnt);
      t.e_rdy = erdy;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      else n_pass++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input vec_t v, input int idx);
      rst      = v.rst;
      in_valid = v.vld;
      in_rd    = v.ird;
      in_data  = v.idata;
      hold     = v.hold;
      rs1      = v.rs1;
      rs2      = v.rs2;
      #1;
      chk($sformatf("v%0d wrt", idx), 32'(wrt), 32'(v.e_wrt));
      chk($sformatf("v%0d rd", idx), 32'(rd), 32'(v.e_rd));
      chk($sformatf("v%0d dataIn", idx), dataIn, v.e_din);
      chk($sformatf("v%0d fwd1_hit", idx), 32'(fwd1_hit), 32'(v.e_h1));
      chk($sformatf("v%0d fwd1_data", idx), fwd1_data, v.e_d1);
      chk($sformatf("v%0d fwd2_hit", idx), 32'(fwd2_hit), 32'(v.e_h2));
      chk($sformatf("v%0d fwd2_data", idx), fwd2_data, v.e_d2);
      chk($sformatf("v%0d pend_count", idx), 32'(pend_count), 32'(v.e_cnt));
      chk($sformatf("v%0d in_ready", idx), 32'(in_ready), 32'(v.e_rdy));
      step();
   endtask

   initial begin
      // Fields: rst vld rd data hold rs1 rs2 | wrt rd dataIn h1 d1 h2 d2 count ready
      // Reset then a single write
      vecs.push_back(mk(0, 0, 0, 0, 0, 2, 3,      0, 0, 0,      0, 0, 0, 0,      0, 1));
      vecs.push_back(mk(0, 1, 2, 'h55, 0, 2, 3,   0, 0, 0,      0, 0, 0, 0,      0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 2, 3,      1, 2, 'h55,   1, 'h55, 0, 0,   1, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 2, 3,      0, 0, 0,      0, 0, 0, 0,      0, 1));
      // Fill under hold, backpressure ignores data, no full-bypass, then drain in order
      vecs.push_back(mk(0, 1, 3, 'h103, 1, 5, 6,  0, 0, 0,      0, 0, 0, 0,      0, 1));
      vecs.push_back(mk(0, 1, 4, 'h104, 1, 5, 6,  0, 3, 'h103,  0, 0, 0, 0,      1, 1));
      vecs.push_back(mk(0, 1, 5, 'h105, 1, 5, 6,  0, 3, 'h103,  0, 0, 0, 0,      2, 1));
      vecs.push_back(mk(0, 1, 6, 'h106, 1, 5, 6,  0, 3, 'h103,  1, 'h105, 0, 0,  3, 1));
      vecs.push_back(mk(0, 1, 9, 'h999, 1, 5, 6,  0, 3, 'h103,  1, 'h105, 1, 'h106, 4, 0));
      vecs.push_back(mk(0, 1, 10, 'haaa, 0, 5, 6, 1, 3, 'h103,  1, 'h105, 1, 'h106, 4, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 5, 6,      1, 4, 'h104,  1, 'h105, 1, 'h106, 3, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 5, 6,      1, 5, 'h105,  1, 'h105, 1, 'h106, 2, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 5, 6,      1, 6, 'h106,  0, 0, 1, 'h106,  1, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 9, 10,     0, 0, 0,      0, 0, 0, 0,      0, 1));
      // Youngest match wins
      vecs.push_back(mk(0, 1, 7, 'h10, 1, 7, 8,   0, 0, 0,      0, 0, 0, 0,      0, 1));
      vecs.push_back(mk(0, 1, 7, 'h20, 1, 7, 8,   0, 7, 'h10,   1, 'h10, 0, 0,   1, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 7, 8,      0, 7, 'h10,   1, 'h20, 0, 0,   2, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 7, 8,      1, 7, 'h10,   1, 'h20, 0, 0,   2, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 7, 8,      1, 7, 'h20,   1, 'h20, 0, 0,   1, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 7, 8,      0, 0, 0,      0, 0, 0, 0,      0, 1));
      // Reset with three pending entries
      vecs.push_back(mk(0, 1, 21, 'h301, 1, 22, 0, 0, 0, 0,     0, 0, 0, 0,      0, 1));
      vecs.push_back(mk(0, 1, 22, 'h302, 1, 22, 0, 0, 21, 'h301, 0, 0, 0, 0,     1, 1));
      vecs.push_back(mk(0, 1, 23, 'h303, 1, 22, 0, 0, 21, 'h301, 1, 'h302, 0, 0, 2, 1));
      vecs.push_back(mk(1, 0, 0, 0, 0, 22, 0,     0, 21, 'h301, 1, 'h302, 0, 0,  3, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 22, 0,     0, 0, 0,      0, 0, 0, 0,      0, 1));

      exp_rd   = '{6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd7};
      exp_data = '{32'h55, 32'h103, 32'h104, 32'h105, 32'h106, 32'h10, 32'h20};
      for (int i = 0; i < 10; i++) begin
         exp_rd.push_back(6'(11 + i));
         exp_data.push_back(32'h200 + 32'(i));
      end
`ifndef REG_ZERO_DISCARD_EN
      exp_rd.push_back(6'd0);
      exp_data.push_back(32'hff);
`endif

      rst      = 1'b1;
      in_valid = 1'b0;
      in_rd    = '0;
      in_data  = '0;
      hold     = 1'b0;
      rs1      = '0;
      rs2      = '0;
      step();

      foreach (vecs[i]) apply(vecs[i], i);

      // Back-to-back stream: one write per cycle, occupancy stays at one
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_rd    = 6'(11 + i);
         in_data  = 32'h200 + 32'(i);
         hold     = 1'b0;
         #1;
         if (i == 0) begin
            chk("stream wrt first", 32'(wrt), 32'd0);
            chk("stream count first", 32'(pend_count), 32'd0);
         end else begin
            chk($sformatf("stream%0d wrt", i), 32'(wrt), 32'd1);
            chk($sformatf("stream%0d rd", i), 32'(rd), 32'(10 + i));
            chk($sformatf("stream%0d dataIn", i), dataIn, 32'h200 + 32'(i - 1));
            chk($sformatf("stream%0d count", i), 32'(pend_count), 32'd1);
         end
         step();
      end
      in_valid = 1'b0;
      #1;
      chk("stream tail rd", 32'(rd), 32'd20);
      chk("stream tail dataIn", dataIn, 32'h209);
      step();
      chk("stream drained", 32'(pend_count), 32'd0);

      // Register 0 write
      in_valid = 1'b1;
      in_rd    = 6'd0;
      in_data  = 32'hff;
      rs1      = 6'd0;
      #1;
      chk("r0 in_ready", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      #1;
`ifdef REG_ZERO_DISCARD_EN
      chk("r0 discard count", 32'(pend_count), 32'd0);
      chk("r0 discard wrt", 32'(wrt), 32'd0);
      chk("r0 discard fwd1_hit", 32'(fwd1_hit), 32'd0);
      step();
      chk("r0 discard wrt later", 32'(wrt), 32'd0);
`else
      chk("r0 count", 32'(pend_count), 32'd1);
      chk("r0 wrt", 32'(wrt), 32'd1);
      chk("r0 dataIn", dataIn, 32'hff);
      chk("r0 fwd1_hit", 32'(fwd1_hit), 32'd1);
      chk("r0 fwd1_data", fwd1_data, 32'hff);
      step();
      chk("r0 drained", 32'(pend_count), 32'd0);
`endif
      step();

      // Everything the register file saw, in order; the reset-discarded entries must be absent
      chk("write log length", 32'(log_rd.size()), 32'(exp_rd.size()));
      for (int i = 0; i < exp_rd.size(); i++) begin
         if (i < log_rd.size()) begin
            chk($sformatf("log%0d rd", i), 32'(log_rd[i]), 32'(exp_rd[i]));
            chk($sformatf("log%0d data", i), log_data[i], exp_data[i]);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/regfile_write_queue.md
Name: regfile_write_queue

Overview:
- Initiator side of the 64x32 register-file write port.
- Accepts (destination, data) results from the execute/memory stages through a valid/ready handshake and buffers them in a small FIFO.
- Drains one entry per cycle into the register file's wrt/rd/dataIn port.
- Forwards still-pending data to the rs1/rs2 read addresses, because the register file samples reads before writes on the same edge.

Parameters:
- DEPTH, 4, queue entries; power of two, minimum 2.
- AW, 6, register address width (64 registers).
- DW, 32, data width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  producer has a result.
- in_ready  out  1  queue can accept; equals !full.
- in_rd  in  AW  destination register of the incoming result.
- in_data  in  DW  incoming result value.
- hold  in  1  suppresses draining; queue still accepts.
- wrt  out  1  write strobe to the register file.
- rd  out  AW  write address to the register file.
- dataIn  out  DW  write data to the register file.
- rs1  in  AW  read address 1 currently presented to the register file.
- rs2  in  AW  read address 2 currently presented to the register file.
- fwd1_hit  out  1  a pending entry matches rs1.
- fwd1_data  out  DW  data of the youngest entry matching rs1.
- fwd2_hit  out  1  a pending entry matches rs2.
- fwd2_data  out  DW  data of the youngest entry matching rs2.
- pend_count  out  AW'(log2(DEPTH)+1)  number of occupied entries.

Behaviour:
- Storage: circular buffer with wr_ptr/rd_ptr of log2(DEPTH)+1 bits; the MSB distinguishes full from empty.
  - empty = (wr_ptr == rd_ptr).
  - full = indices equal and MSBs differ.
- Reset (rst=1 at posedge): pointers to 0, all entry valid bits cleared, pend_count=0. Outputs then read wrt=0, rd=0, dataIn=0, fwd*_hit=0, fwd*_data=0, in_ready=1.
- Reset mid-operation: all pending writes are discarded; nothing is written to the register file in that cycle.
- Enqueue: occurs at posedge when in_valid && in_ready. The entry is written at wr_ptr and wr_ptr increments, wrapping modulo 2*DEPTH.
- Backpressure:
  - in_ready=0 when full, even if a dequeue happens in the same cycle (no full-bypass).
  - in_data and in_rd are ignored while in_ready=0.
- Drain (combinational from head):
  - wrt = !empty && !hold && !rst.
  - rd and dataIn show the head entry whenever non-empty, else 0.
  - The head is dequeued at every posedge where wrt=1; the register file captures the write on that same edge.
- Simultaneous enqueue and dequeue: both occur and pend_count is unchanged.
- Empty queue: a new entry cannot be written the same cycle it arrives. Minimum latency is in_valid at edge N, wrt high during cycle N+1, register updated at edge N+1.
- Forwarding:
  - Combinational search over all occupied entries, including the head being written this cycle.
  - On multiple matches, the youngest (closest to wr_ptr) wins.
  - On no match, hit=0 and data=0.
  - rs1 and rs2 are searched independently.
- Ordering: writes leave in strict arrival order, so duplicate rd entries are all written and the last write prevails.
- pend_count = wr_ptr - rd_ptr, computed in pointer width.

Optional Feature:
- Macro: REG_ZERO_DISCARD_EN.
- Defined:
  - An accepted in_rd==0 is acknowledged (in_ready as normal) but not stored.
  - Register 0 never appears on wrt/rd.
  - rs==0 never forward-hits.
- Undefined: register 0 is treated like any other register.

Decomposition:
- Package regfile_pkg holds:
  - Constants REG_AW=6, REG_DW=32, REG_COUNT=64.
  - Typedefs reg_addr_t, reg_data_t.
  - struct wq_entry_t {valid, rd, data}.
- One sub-module, wq_fwd_match: priority search returning youngest hit/data for one read address. It is instantiated twice, once each for rs1 and rs2.

Test Plan:
- Reset then single write: rst 1 cycle; in_rd=2, in_data=0x55 for one cycle -> next cycle wrt=1, rd=2, dataIn=0x55; register 2 reads 0x55 afterwards; pend_count returns to 0.
- Fill with hold: hold=1; enqueue rd 3,4,5,6 -> in_ready=0 after 4th, pend_count=4, wrt=0. Release hold -> four consecutive wrt cycles in order 3,4,5,6.
- Forwarding youngest: hold=1; enqueue (7,0x10), (7,0x20); rs1=7 -> fwd1_hit=1, fwd1_data=0x20. rs2=8 -> fwd2_hit=0, fwd2_data=0.
- Simultaneous enqueue/dequeue: steady in_valid with hold=0 for 10 cycles -> one write per cycle, pend_count stays 1, data order preserved.
- Reset mid-drain: 3 entries pending, assert rst -> no wrt that cycle, pend_count=0, in_ready=1, entries never written.
- With REG_ZERO_DISCARD_EN: enqueue (0,0xFF) -> in_ready=1, pend_count stays 0, wrt never asserted, rs1=0 gives fwd1_hit=0.
